// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
package piso_tx_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/piso_core.sv
// WIDTH-bit loadable left-shift register; zeros enter at the LSB, MSB is the serial tap.
module piso_core
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             msb,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;

  // Load wins over shift so a streamed word replaces the last bit cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift_en) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign q   = sr_q;
  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial transmit controller: valid/ready word intake, MSB-first framing with start/end strobes.
// Optional even-parity bit per frame when PARITY_EN is defined.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  input  logic             pause,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            last_bit;
  logic            core_msb;
  logic [WIDTH-1:0] core_q;
  logic            shift_en;
  logic            unused_q;

  assign din_ready = !pause && ((state_q == IDLE) || last_bit);
  assign accept    = din_valid && din_ready;
  assign shift_en  = !pause && (state_q == SHIFT) && !accept;
  assign unused_q  = ^core_q;

  piso_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (reset),
    .load     (accept),
    .shift_en (shift_en),
    .d        (din),
    .msb      (core_msb),
    .q        (core_q)
  );

`ifdef PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^din;
    end
  end

  assign last_bit = (state_q == PAR);
  assign sout     = (state_q == PAR) ? parity_q : core_msb;
`else
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign sout     = core_msb;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt returns to 0 whenever a frame's data bits finish, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pause) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d = accept ? SHIFT : IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef PARITY_EN
        PAR: begin
          cnt_d   = '0;
          state_d = accept ? SHIFT : IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign sout_valid  = !pause && busy;
  assign frame_start = sout_valid && (state_q == SHIFT) && (cnt_q == '0);
  assign frame_end   = sout_valid && last_bit;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl (WIDTH=4); adapts frame length when PARITY_EN is defined.
module tb_piso_tx_ctrl;

`ifdef PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  // Expected serial streams, first bit at [4]; bit [0] is the even-parity bit.
  localparam logic [4:0] E1011 = 5'b10111;
  localparam logic [4:0] E0110 = 5'b01100;
  localparam logic [4:0] E1001 = 5'b10010;

  logic       clk = 1'b0;
  logic       reset;
  logic       din_valid;
  logic [3:0] din;
  logic       din_ready;
  logic       pause;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  piso_tx_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .pause       (pause),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic e_sout, input logic e_sv,
                          input logic e_fs, input logic e_fe, input logic e_busy,
                          input logic e_rdy);
    chk({tag, " sout"},        32'(sout),        32'(e_sout));
    chk({tag, " sout_valid"},  32'(sout_valid),  32'(e_sv));
    chk({tag, " frame_start"}, 32'(frame_start), 32'(e_fs));
    chk({tag, " frame_end"},   32'(frame_end),   32'(e_fe));
    chk({tag, " busy"},        32'(busy),        32'(e_busy));
    chk({tag, " din_ready"},   32'(din_ready),   32'(e_rdy));
  endtask

  // Caller is just after an active edge; ends sampled in the idle cycle after the frame.
  task automatic run_frame(input string tag, input logic [3:0] w, input logic [4:0] e);
    din_valid = 1'b1;
    din       = w;
    @(negedge clk);
    chk({tag, " c0 din_ready"}, 32'(din_ready), 32'd1);
    for (int i = 1; i <= FL; i++) begin
      next_cycle();
      din_valid = 1'b0;
      din       = 4'h0;
      @(negedge clk);
      chk_outs($sformatf("%s c%0d", tag, i), e[5-i], 1'b1, i == 1, i == FL, 1'b1, i == FL);
    end
    next_cycle();
    @(negedge clk);
    chk_outs({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    pause     = 1'b0;
    din_valid = 1'b0;
    din       = 4'h0;

    @(negedge clk);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;

    // Single word
    run_frame("single", 4'b1011, E1011);

    // Back-to-back streaming with din_valid held
    next_cycle();
    din_valid = 1'b1;
    din       = 4'b1011;
    @(negedge clk);
    chk("b2b c0 din_ready", 32'(din_ready), 32'd1);
    for (int i = 1; i <= 2 * FL; i++) begin
      next_cycle();
      din_valid = (i <= FL);
      din       = 4'b0110;
      @(negedge clk);
      chk_outs($sformatf("b2b c%0d", i),
               (i <= FL) ? E1011[5-i] : E0110[5-(i-FL)], 1'b1,
               (i == 1) || (i == FL + 1), (i == FL) || (i == 2 * FL), 1'b1,
               (i == FL) || (i == 2 * FL));
    end
    next_cycle();
    din_valid = 1'b0;
    @(negedge clk);
    chk_outs("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pause for two cycles during the second bit of 1001
    next_cycle();
    din_valid = 1'b1;
    din       = 4'b1001;
    @(negedge clk);
    chk("pause c0 din_ready", 32'(din_ready), 32'd1);
    for (int i = 1; i <= FL + 2; i++) begin
      next_cycle();
      din_valid = 1'b0;
      pause     = (i == 2) || (i == 3);
      @(negedge clk);
      if (i == 1)
        chk_outs("pause c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      else if (pause)
        chk_outs($sformatf("pause c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else
        chk_outs($sformatf("pause c%0d", i), E1001[5-(i-2)], 1'b1, 1'b0,
                 i == FL + 2, 1'b1, i == FL + 2);
    end
    next_cycle();
    pause = 1'b0;
    @(negedge clk);
    chk_outs("pause idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Busy rejection: 1111 offered while the frame is in flight
    next_cycle();
    din_valid = 1'b1;
    din       = 4'b1011;
    @(negedge clk);
    for (int i = 1; i <= FL; i++) begin
      next_cycle();
      din_valid = (i <= 3);
      din       = 4'b1111;
      @(negedge clk);
      chk_outs($sformatf("rej c%0d", i), E1011[5-i], 1'b1, i == 1, i == FL, 1'b1, i == FL);
    end
    next_cycle();
    din_valid = 1'b0;
    @(negedge clk);
    chk_outs("rej idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset asserted mid-frame
    next_cycle();
    din_valid = 1'b1;
    din       = 4'b1011;
    next_cycle();
    din_valid = 1'b0;
    @(negedge clk);
    chk_outs("rst c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk_outs("rst c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk_outs("rst rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    run_frame("post_rst", 4'b0110, E0110);

`ifdef PARITY_EN
    next_cycle();
    run_frame("par1001", 4'b1001, E1001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
